// File: rtl/ysyx_22041211_isram.sv
// Instruction-side AXI4-Lite read slave (AR/R only) with fixed or LFSR-jittered latency.
// Word reads are issued on the pmem_* port; the simulation memory answers combinationally.
module ysyx_22041211_isram #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             LATENCY    = 1,
  parameter int unsigned             RAND_DELAY = 0,
  parameter logic [ADDR_WIDTH-1:0]   MEM_BASE   = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0]   MEM_SIZE   = 32'h0800_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  pmem_ren,
  output logic [ADDR_WIDTH-1:0] pmem_raddr,
  output logic [7:0]            pmem_rmask,
  input  logic [DATA_WIDTH-1:0] pmem_rdata
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("ysyx_22041211_isram: LATENCY must lie within 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [4:0]          LAT_W    = 5'(LATENCY);
  localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, MEM_BASE};
  localparam logic [ADDR_WIDTH:0] END_EXT  = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [7:0]            lfsr_q;

  logic                  ar_hs;
  logic [4:0]            delay;
  logic                  acc_en;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [ADDR_WIDTH:0]   acc_addr_ext;
  logic                  acc_misaligned;
  logic                  acc_out_of_range;
  logic                  lfsr_fb;

  assign arready = (state_q == ST_IDLE) && !rst;
  assign rvalid  = (state_q == ST_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign ar_hs   = arvalid && arready;

  // Taps 8,6,5,4 give a maximal-length 255-state sequence.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign delay   = LAT_W + ((RAND_DELAY != 0) ? {3'b000, lfsr_q[1:0]} : 5'd0);

  // 33-bit compare keeps MEM_BASE+MEM_SIZE from wrapping at the top of the space.
  assign acc_addr_ext     = {1'b0, acc_addr};
  assign acc_misaligned   = (acc_addr[1:0] != 2'b00);
  assign acc_out_of_range = (acc_addr_ext < BASE_EXT) || (acc_addr_ext >= END_EXT);

  assign pmem_ren   = acc_en && !rst && !acc_misaligned && !acc_out_of_range;
  assign pmem_raddr = acc_addr;
  assign pmem_rmask = 8'b0000_1111;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    acc_en   = 1'b0;
    acc_addr = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          addr_d   = araddr;
          acc_addr = araddr;
          if (delay == 5'd1) begin
            acc_en  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = delay - 5'd1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 5'd1) begin
          acc_en  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_RESP: begin
        if (rready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Misalignment takes priority over the range check.
    if (acc_en) begin
      if (acc_misaligned) begin
        rresp_d = RESP_SLVERR;
        rdata_d = '0;
      end else if (acc_out_of_range) begin
        rresp_d = RESP_DECERR;
        rdata_d = '0;
      end else begin
        rresp_d = RESP_OKAY;
        rdata_d = pmem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      addr_q  <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      lfsr_q  <= 8'hA5;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      lfsr_q  <= {lfsr_q[6:0], lfsr_fb};
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_isram.sv
// Directed bench for ysyx_22041211_isram: four instances with different latency settings
// share one clock, a behavioural word memory and per-instance read-call counters.
module tb_ysyx_22041211_isram;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [N];
  logic [31:0] araddr     [N];
  logic        arvalid    [N];
  logic        rready     [N];
  logic        arready    [N];
  logic        rvalid     [N];
  logic [31:0] rdata      [N];
  logic [1:0]  rresp      [N];
  logic        pmem_ren   [N];
  logic [31:0] pmem_raddr [N];
  logic [7:0]  pmem_rmask [N];
  logic [31:0] pmem_rdata [N];

  int calls    [N] = '{default: 0};
  int mask_bad [N] = '{default: 0};
  int overlap  [N] = '{default: 0};

  int passed = 0;
  int failed = 0;
  int total  = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 4 : (gi == 2) ? 2 : 6;
    localparam int RND = (gi == 2) ? 1 : 0;
    ysyx_22041211_isram #(
      .LATENCY    (LAT),
      .RAND_DELAY (RND)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[gi]),
      .araddr     (araddr[gi]),
      .arvalid    (arvalid[gi]),
      .arready    (arready[gi]),
      .rdata      (rdata[gi]),
      .rresp      (rresp[gi]),
      .rvalid     (rvalid[gi]),
      .rready     (rready[gi]),
      .pmem_ren   (pmem_ren[gi]),
      .pmem_raddr (pmem_raddr[gi]),
      .pmem_rmask (pmem_rmask[gi]),
      .pmem_rdata (pmem_rdata[gi])
    );
    assign pmem_rdata[gi] = mem_model(pmem_raddr[gi]);
  end

  // Memory-call log: one entry per edge on which a read is requested.
  always @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      if (pmem_ren[j] === 1'b1) begin
        calls[j]++;
        if (pmem_rmask[j] !== 8'h0F) mask_bad[j]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int j = 0; j < N; j++) begin
      if (arready[j] === 1'b1 && rvalid[j] === 1'b1) overlap[j]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int k, input logic [31:0] a, input int stall,
                       output int lat, output logic [31:0] d, output logic [1:0] r);
    int w;
    araddr[k]  = a;
    arvalid[k] = 1'b1;
    rready[k]  = (stall == 0);
    w = 0;
    while (arready[k] !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    chk("arready_wait", 32'(w < 40), 32'd1);
    tick();
    arvalid[k] = 1'b0;
    araddr[k]  = 32'hDEAD_BEEC;
    lat = 1;
    while (rvalid[k] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    d = rdata[k];
    r = rresp[k];
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_rvalid", 32'(rvalid[k]), 32'd1);
      chk("stall_rdata", rdata[k], d);
    end
    rready[k] = 1'b1;
    tick();
    chk("post_r_rvalid", 32'(rvalid[k]), 32'd0);
    chk("post_r_arready", 32'(arready[k]), 32'd1);
    $display("isram%0d fetch addr=%h lat=%0d rdata=%h rresp=%b", k, a, lat, d, r);
  endtask

  logic [31:0] tab_addr [4];
  logic [1:0]  tab_resp [4];
  int          tab_call [4];

  initial begin
    int          lat;
    logic [31:0] d;
    logic [1:0]  r;
    int          c0;
    int          bad;
    logic [3:0]  seen;
    logic [31:0] a;

    for (int k = 0; k < N; k++) begin
      rst[k]     = 1'b1;
      arvalid[k] = 1'b0;
      rready[k]  = 1'b0;
      araddr[k]  = 32'h0;
    end
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      chk("reset_arready", 32'(arready[k]), 32'd0);
      chk("reset_rvalid", 32'(rvalid[k]), 32'd0);
    end
    chk("reset_rdata", rdata[0], 32'h0);
    chk("reset_rresp", 32'(rresp[0]), 32'd0);
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    tick();
    for (int k = 0; k < N; k++) chk("first_cycle_arready", 32'(arready[k]), 32'd1);

    // LATENCY=1 basic fetch
    fetch(0, 32'h8000_0000, 0, lat, d, r);
    chk("l1_latency", 32'(lat), 32'd1);
    chk("l1_rdata", d, 32'h0000_0413);
    chk("l1_rresp", 32'(r), 32'd0);

    // LATENCY=4 with a three-cycle R stall
    c0 = calls[1];
    fetch(1, 32'h8000_0010, 3, lat, d, r);
    chk("l4_latency", 32'(lat), 32'd4);
    chk("l4_rdata", d, mem_model(32'h8000_0010));
    chk("l4_rresp", 32'(r), 32'd0);
    chk("l4_calls", 32'(calls[1] - c0), 32'd1);

    // Error responses and the top boundary of the region
    tab_addr = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8800_0000, 32'h87FF_FFFC};
    tab_resp = '{2'b10, 2'b11, 2'b11, 2'b00};
    tab_call = '{0, 0, 0, 1};
    for (int t = 0; t < 4; t++) begin
      c0 = calls[0];
      fetch(0, tab_addr[t], 0, lat, d, r);
      chk("err_rresp", 32'(r), 32'(tab_resp[t]));
      chk("err_rdata", d, (tab_call[t] != 0) ? mem_model(tab_addr[t]) : 32'h0);
      chk("err_calls", 32'(calls[0] - c0), 32'(tab_call[t]));
    end

    // RAND_DELAY=1, LATENCY=2: 200 sequential fetches
    seen = 4'b0000;
    for (int i = 0; i < 200; i++) begin
      a = 32'h8000_0000 + 32'(i) * 32'd4;
      fetch(2, a, 0, lat, d, r);
      chk("rand_lat_range", 32'(lat >= 2 && lat <= 5), 32'd1);
      if (lat >= 2 && lat <= 5) seen[lat-2] = 1'b1;
      chk("rand_rdata", d, mem_model(a));
      chk("rand_rresp", 32'(r), 32'd0);
    end
    chk("rand_all_delays_seen", 32'(seen), 32'hF);

    // Reset during WAIT drops the request
    araddr[3]  = 32'h8000_0000;
    arvalid[3] = 1'b1;
    rready[3]  = 1'b1;
    tick();
    arvalid[3] = 1'b0;
    tick();
    tick();
    tick();
    c0 = calls[3];
    rst[3] = 1'b1;
    tick();
    chk("rst_wait_rvalid", 32'(rvalid[3]), 32'd0);
    chk("rst_wait_arready", 32'(arready[3]), 32'd0);
    rst[3] = 1'b0;
    tick();
    chk("rst_release_arready", 32'(arready[3]), 32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rvalid[3] !== 1'b0) bad++;
    end
    chk("rst_dropped_rvalid", 32'(bad), 32'd0);
    chk("rst_dropped_calls", 32'(calls[3] - c0), 32'd0);
    fetch(3, 32'h8000_0004, 0, lat, d, r);
    chk("l6_latency", 32'(lat), 32'd6);
    chk("l6_rdata", d, mem_model(32'h8000_0004));
    chk("l6_calls", 32'(calls[3] - c0), 32'd1);

    // Idle bus with rready held high
    rready[3]  = 1'b1;
    arvalid[3] = 1'b0;
    c0 = calls[3];
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rvalid[3] !== 1'b0 || arready[3] !== 1'b1) bad++;
    end
    chk("idle_state", 32'(bad), 32'd0);
    chk("idle_calls", 32'(calls[3] - c0), 32'd0);

    for (int k = 0; k < N; k++) begin
      chk("rmask", 32'(mask_bad[k]), 32'd0);
      chk("ar_r_overlap", 32'(overlap[k]), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
